dram_arbiter: RTL and testbench

//   Shares the single-port data DRAM (async read, byte-enabled sync write) between two requesters:

---
 rtl/dram_arbiter_pkg.sv | 14 +
 rtl/dram_arbiter_lane_align.sv | 47 ++++
 rtl/dram_arbiter.sv | 141 ++++++++++++++
 tb/tb_dram_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arbiter_pkg.sv
// rtl/dram_arbiter_pkg.sv - access size codes and FSM states shared by the DRAM arbiter
package dram_arbiter_pkg;

  localparam logic [1:0] SIZE_B   = 2'd0;
  localparam logic [1:0] SIZE_H   = 2'd1;
  localparam logic [1:0] SIZE_W   = 2'd2;
  localparam logic [1:0] SIZE_RSV = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/dram_arbiter_lane_align.sv
// rtl/dram_arbiter_lane_align.sv - byte-lane enables, store replication and load alignment/extension
module dram_arbiter_lane_align
  import dram_arbiter_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] spo,
  input  logic        is_unsigned,
  output logic [3:0]  we,
  output logic [31:0] d,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    we       = 4'b0000;
    d        = 32'h0;
    rdata    = 32'h0;
    misalign = 1'b0;
    // A byte shift by addr_lo also serves halves, since aligned halves have addr_lo[0] = 0.
    shifted  = spo >> {addr_lo, 3'b000};
    case (size)
      SIZE_B: begin
        we    = 4'b0001 << addr_lo;
        d     = {4{wdata[7:0]}};
        rdata = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        misalign = addr_lo[0];
        we       = addr_lo[1] ? 4'b1100 : 4'b0011;
        d        = {2{wdata[15:0]}};
        rdata    = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      end
      SIZE_W: begin
        misalign = |addr_lo;
        we       = 4'b1111;
        d        = wdata;
        rdata    = spo;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin two-port arbiter for the single-port data DRAM
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_we,
  input  logic [1:0]           req0_size,
  input  logic                 req0_unsigned,
  input  logic [31:0]          req0_addr,
  input  logic [31:0]          req0_wdata,
  output logic                 rsp0_valid,
  output logic [31:0]          rsp0_rdata,
  output logic                 rsp0_err,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_we,
  input  logic [1:0]           req1_size,
  input  logic                 req1_unsigned,
  input  logic [31:0]          req1_addr,
  input  logic [31:0]          req1_wdata,
  output logic                 rsp1_valid,
  output logic [31:0]          rsp1_rdata,
  output logic                 rsp1_err,
  output logic [ADDR_BITS-1:0] dram_a,
  output logic [3:0]           dram_we,
  output logic [31:0]          dram_d,
  input  logic [31:0]          dram_spo
);

  state_t      state, state_nxt;
  logic        rr_last;
  logic        cur_port;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_uns;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        any_valid;
  logic        grant;
  logic        in_access;
  logic        range_err;
  logic        acc_err;
  logic [3:0]  al_we;
  logic [31:0] al_d;
  logic [31:0] al_rdata;
  logic        al_misalign;

  assign any_valid = req0_valid | req1_valid;
  // On a tie the port that did not win last time gets the slot.
  assign grant     = (req0_valid & req1_valid) ? ~rr_last : req1_valid;
  assign in_access = (state == ST_ACCESS);
  assign range_err = |lat_addr[31:ADDR_BITS+2];
  assign acc_err   = al_misalign | range_err;

  dram_arbiter_lane_align u_align (
    .size        (lat_size),
    .addr_lo     (lat_addr[1:0]),
    .wdata       (lat_wdata),
    .spo         (dram_spo),
    .is_unsigned (lat_uns),
    .we          (al_we),
    .d           (al_d),
    .rdata       (al_rdata),
    .misalign    (al_misalign)
  );

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_valid) begin
          req0_ready = ~grant;
          req1_ready = grant;
          state_nxt  = ST_ACCESS;
        end
      end
      ST_ACCESS: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (rst) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_last     <= 1'b1;
      cur_port    <= 1'b0;
      lat_we      <= 1'b0;
      lat_size    <= SIZE_B;
      lat_uns     <= 1'b0;
      lat_addr    <= 32'h0;
      lat_wdata   <= 32'h0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      rsp_valid_q <= 2'b00;
      if (state == ST_IDLE && any_valid) begin
        rr_last   <= grant;
        cur_port  <= grant;
        lat_we    <= grant ? req1_we       : req0_we;
        lat_size  <= grant ? req1_size     : req0_size;
        lat_uns   <= grant ? req1_unsigned : req0_unsigned;
        lat_addr  <= grant ? req1_addr     : req0_addr;
        lat_wdata <= grant ? req1_wdata    : req0_wdata;
      end
      if (in_access) begin
        rsp_valid_q <= cur_port ? 2'b10 : 2'b01;
        rsp_err_q   <= acc_err;
        rsp_rdata_q <= (acc_err | lat_we) ? 32'h0 : al_rdata;
      end
    end
  end

  assign dram_a  = in_access ? lat_addr[ADDR_BITS+1:2] : '0;
  assign dram_d  = in_access ? al_d : 32'h0;
  assign dram_we = (in_access && lat_we && !acc_err && !rst) ? al_we : 4'b0000;

  assign rsp0_valid = rsp_valid_q[0] & ~rst;
  assign rsp1_valid = rsp_valid_q[1] & ~rst;
  assign rsp0_rdata = rsp0_valid ? rsp_rdata_q : 32'h0;
  assign rsp1_rdata = rsp1_valid ? rsp_rdata_q : 32'h0;
  assign rsp0_err   = rsp0_valid & rsp_err_q;
  assign rsp1_err   = rsp1_valid & rsp_err_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - randomized scoreboard bench for dram_arbiter against a byte-level memory model
module tb_dram_arbiter;

  localparam int          AB    = 16;
  localparam logic [31:0] LIMIT = 32'h1 << (AB + 2);
  localparam logic [1:0]  SZ_B  = 2'd0;
  localparam logic [1:0]  SZ_H  = 2'd1;
  localparam logic [1:0]  SZ_W  = 2'd2;
  localparam logic [1:0]  SZ_R  = 2'd3;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    v   = 2'b00;
  req_t          r [2];
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0]   rsp0_rdata, rsp1_rdata;
  logic [AB-1:0] dram_a;
  logic [3:0]    dram_we;
  logic [31:0]   dram_d, dram_spo;
  logic [31:0]   mem [0:(1<<AB)-1];

  dram_arbiter #(.ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_we(r[0].we), .req0_size(r[0].size),
    .req0_unsigned(r[0].uns), .req0_addr(r[0].addr), .req0_wdata(r[0].wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_we(r[1].we), .req1_size(r[1].size),
    .req1_unsigned(r[1].uns), .req1_addr(r[1].addr), .req1_wdata(r[1].wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .dram_a(dram_a), .dram_we(dram_we), .dram_d(dram_d), .dram_spo(dram_spo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(int i);
    return (i < 64) ? ((i * 32'h9E3779B9) ^ 32'h5A5A1234) : 32'h0;
  endfunction

  initial begin
    for (int i = 0; i < (1 << AB); i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      for (int b = 0; b < 4; b++)
        if (dram_we[b]) mem[dram_a][8*b +: 8] = dram_d[8*b +: 8];
    end
  end
  assign dram_spo = mem[dram_a];

  // Reference model: byte-addressed memory holding only bytes written so far.
  logic [7:0] ref_b [int];

  function automatic logic [7:0] rd_byte(int a);
    logic [31:0] w;
    if (ref_b.exists(a)) return ref_b[a];
    w = init_word(a / 4);
    return w[8*(a%4) +: 8];
  endfunction

  int   checks = 0, errors = 0;
  exp_t eq [2][$];
  bit   hs_pend = 1'b0;
  int   pend_port = 0;
  req_t pend_req;
  int   last_win = 1;
  int   hs_count [2] = '{0, 0};
  bit   done = 1'b0;
  int   timeouts = 0;
  int   issued = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_rsp(int p, logic vld, logic [31:0] rd, logic er);
    exp_t e;
    if (vld) begin
      if (eq[p].size() == 0) chk($sformatf("rsp%0d_valid_unexpected", p), {31'd0, vld}, 32'd0);
      else begin
        e = eq[p].pop_front();
        chk($sformatf("rsp%0d_cycle", p), cyc, e.due);
        chk($sformatf("rsp%0d_rdata", p), rd, e.rdata);
        chk($sformatf("rsp%0d_err", p), {31'd0, er}, {31'd0, e.err});
      end
    end else if (eq[p].size() != 0 && eq[p][0].due <= cyc) begin
      chk($sformatf("rsp%0d_missing", p), {31'd0, vld}, 32'd1);
      void'(eq[p].pop_front());
    end
  endtask

  task automatic do_access();
    req_t        q;
    int          nb, a, lane;
    bit          err;
    logic [3:0]  we_e;
    logic [31:0] d_e, mask, val;
    exp_t        e;
    q    = pend_req;
    nb   = 1 << q.size;
    err  = (q.size == SZ_R) || ((int'(q.addr[1:0]) % nb) != 0) || (q.addr >= LIMIT);
    we_e = 4'b0000; d_e = 32'h0; mask = 32'h0; val = 32'h0;
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        a    = int'(q.addr) + i;
        lane = int'(q.addr[1:0]) + i;
        if (q.we) begin
          ref_b[a]            = q.wdata[8*i +: 8];
          we_e[lane]          = 1'b1;
          d_e[8*lane +: 8]    = q.wdata[8*i +: 8];
          mask[8*lane +: 8]   = 8'hFF;
        end else begin
          val[8*i +: 8] = rd_byte(a);
        end
      end
      if (!q.we && nb < 4 && !q.uns && val[8*nb-1]) val = val | ~((32'h1 << (8*nb)) - 32'h1);
    end
    chk("dram_we", {28'd0, dram_we}, {28'd0, we_e});
    if (!err) chk("dram_a", {16'd0, dram_a}, q.addr >> 2);
    if (!err && q.we) chk("dram_d", dram_d & mask, d_e);
    e.due   = cyc + 1;
    e.rdata = (err || q.we) ? 32'h0 : val;
    e.err   = err;
    eq[pend_port].push_back(e);
  endtask

  initial begin : monitor
    int g;
    bit busy;
    forever begin
      @(negedge clk);
      if (done) break;
      if (rst) begin
        chk("reset_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("reset_rsp", {28'd0, rsp1_valid, rsp1_err, rsp0_valid, rsp0_err}, 32'd0);
        chk("reset_rdata", rsp0_rdata | rsp1_rdata, 32'd0);
        chk("reset_dram_we", {28'd0, dram_we}, 32'd0);
        eq[0].delete();
        eq[1].delete();
        hs_pend  = 1'b0;
        last_win = 1;
      end else begin
        check_rsp(0, rsp0_valid, rsp0_rdata, rsp0_err);
        check_rsp(1, rsp1_valid, rsp1_rdata, rsp1_err);
        busy = hs_pend;
        if (hs_pend) begin
          do_access();
          hs_pend = 1'b0;
        end else begin
          chk("idle_dram_we", {28'd0, dram_we}, 32'd0);
        end
        g = -1;
        if (!busy) begin
          if (v[0] && v[1]) g = (last_win == 0) ? 1 : 0;
          else if (v[0])    g = 0;
          else if (v[1])    g = 1;
        end
        chk("ready", {30'd0, req1_ready, req0_ready}, {30'd0, g == 1, g == 0});
        if (g >= 0) begin
          hs_pend   = 1'b1;
          pend_port = g;
          pend_req  = r[g];
          last_win  = g;
          hs_count[g]++;
        end
      end
    end
    chk("leftover_rsp", eq[0].size() + eq[1].size(), 32'd0);
    chk("handshakes", hs_count[0] + hs_count[1], issued);
    chk("timeouts", timeouts, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  req_t sq [2][$];
  int   seen [2] = '{0, 0};
  bit   gappy = 1'b0;

  task automatic push(int p, logic we, logic [1:0] size, logic uns, logic [31:0] addr, logic [31:0] wdata);
    req_t q;
    q.we = we; q.size = size; q.uns = uns; q.addr = addr; q.wdata = wdata;
    sq[p].push_back(q);
    issued++;
  endtask

  task automatic drive_step();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (hs_count[p] != seen[p]) begin
        seen[p] = hs_count[p];
        v[p]    = 1'b0;
      end
      if (!v[p] && sq[p].size() != 0 && (!gappy || $urandom_range(1, 0) == 1)) begin
        r[p] = sq[p].pop_front();
        v[p] = 1'b1;
      end
    end
  endtask

  task automatic run_all();
    int n;
    n = 0;
    while ((sq[0].size() + sq[1].size() != 0 || v != 2'b00 || hs_pend ||
            eq[0].size() + eq[1].size() != 0) && n < 6000) begin
      drive_step();
      n++;
    end
    if (n >= 6000) timeouts++;
  endtask

  initial begin : stimulus
    int          h0, n, p, sel;
    logic [1:0]  sz;
    logic [31:0] ad;
    r[0] = '0;
    r[1] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    push(0, 1, SZ_W, 0, 32'h10, 32'hDEADBEEF);
    push(0, 0, SZ_W, 0, 32'h10, 32'h0);
    push(0, 1, SZ_W, 0, 32'h10, 32'h0);
    push(0, 1, SZ_B, 0, 32'h13, 32'h80);
    push(0, 0, SZ_B, 0, 32'h13, 32'h0);
    push(0, 0, SZ_B, 1, 32'h13, 32'h0);
    push(0, 0, SZ_H, 1, 32'h12, 32'h0);
    run_all();

    for (int i = 0; i < 3; i++) begin
      push(0, 0, SZ_W, 0, 32'h4 * i, 32'h0);
      push(1, 1, SZ_W, 0, 32'h30 + 32'h4 * i, 32'h1111_0000 + i);
    end
    run_all();

    push(0, 1, SZ_H, 0, 32'h11, 32'hFFFF);
    push(1, 0, SZ_W, 0, 32'h2, 32'h0);
    push(0, 0, SZ_W, 0, LIMIT, 32'h0);
    push(1, 1, SZ_R, 0, 32'h20, 32'h1234);
    push(1, 1, SZ_W, 0, LIMIT + 32'h10, 32'h5555AAAA);
    run_all();

    push(0, 1, SZ_W, 0, 32'h20, 32'hCAFEF00D);
    h0 = seen[0];
    n  = 0;
    while (seen[0] == h0 && n < 100) begin
      drive_step();
      n++;
    end
    if (n >= 100) timeouts++;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push(0, 0, SZ_W, 0, 32'h20, 32'h0);
    push(1, 0, SZ_W, 0, 32'h24, 32'h0);
    run_all();

    for (int i = 0; i < 5; i++) push(1, 0, SZ_W, 0, 32'h4 * i, 32'h0);
    run_all();

    gappy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      p   = int'($urandom_range(1, 0));
      sel = int'($urandom_range(15, 0));
      sz  = (sel == 0) ? SZ_R : 2'($urandom_range(2, 0));
      ad  = (sel == 1) ? ($urandom | LIMIT) : 32'($urandom_range(63, 0));
      if (sel >= 8 && sz != SZ_R) ad = ad & ~((32'h1 << sz) - 32'h1);
      push(p, 1'($urandom_range(1, 0)), sz, 1'($urandom_range(1, 0)), ad, $urandom);
    end
    run_all();

    repeat (3) drive_step();
    done = 1'b1;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

endmodule
